// File: rtl/tw_horizontal_tx_pkg.sv
// ============================================================================
// Module : tw_horizontal_tx_pkg
// Brief  : Shared widths, ROM write codes and FSM encoding for the horizontal
//          twiddle-update interface (transmit side and ROM side).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tw_horizontal_tx_pkg;

    localparam int P_WIDTH         = 128;
    localparam int HORIZONTAL_DW   = 64;
    localparam int INIT_STORE_DATA = 4;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_HI   = 2'd1;
    localparam logic [1:0] W_LO   = 2'd2;

    typedef enum logic [2:0] {
        ST_FILL    = 3'd0,
        ST_WAIT_EN = 3'd1,
        ST_SEND_HI = 3'd2,
        ST_SEND_LO = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tw_horizontal_tx.sv
// ============================================================================
// Module : tw_horizontal_tx
// Brief  : Buffers one 4-entry twiddle group and replays it to the ROM as a
//          code-1 (upper halves) / code-2 (lower halves) burst plus idle gap.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tw_horizontal_tx
    import tw_horizontal_tx_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_load_valid,
    input  logic [P_WIDTH-1:0]       i_load_data,
    output logic                     o_load_ready,
    input  logic                     i_tx_en,
    output logic [HORIZONTAL_DW-1:0] o_horizontal_data_out,
    output logic [1:0]               o_rom6_w,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int              c_GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_CYCLES - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [1:0]               r_idx;
    logic [1:0]               w_idx_nxt;
    logic [c_GW-1:0]          r_gap;
    logic [c_GW-1:0]          w_gap_nxt;
    logic                     r_ready;
    logic                     w_ready_nxt;
    logic [1:0]               r_code;
    logic [1:0]               w_code_nxt;
    logic [HORIZONTAL_DW-1:0] r_data;
    logic [HORIZONTAL_DW-1:0] w_data_nxt;
    logic                     r_busy;
    logic                     w_busy_nxt;
    logic                     r_done;
    logic                     w_done_nxt;
    logic                     w_accept;
    logic [P_WIDTH-1:0]       r_buf [INIT_STORE_DATA];

    assign w_accept = i_load_valid & r_ready;

    // Group buffer: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_idx] <= i_load_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = r_gap;
        case (r_state)
            ST_FILL: begin
                if (w_accept) begin
                    w_idx_nxt = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_state_nxt = ST_WAIT_EN;
                    end
                end
            end
            ST_WAIT_EN: begin
                if (i_tx_en) begin
                    w_state_nxt = ST_SEND_HI;
                    w_idx_nxt   = 2'd0;
                end
            end
            ST_SEND_HI: begin
                w_idx_nxt = r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    w_state_nxt = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                w_idx_nxt = r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = '0;
                end
            end
            ST_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = ST_FILL;
                    w_idx_nxt   = 2'd0;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered bus lines up
    // with the state it belongs to; the hi->lo index wrap is implicit.
    always_comb begin
        w_code_nxt  = W_IDLE;
        w_data_nxt  = '0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_ready_nxt = (w_state_nxt == ST_FILL);
        case (w_state_nxt)
            ST_SEND_HI: begin
                w_code_nxt = W_HI;
                w_data_nxt = r_buf[w_idx_nxt][P_WIDTH-1:HORIZONTAL_DW];
                w_busy_nxt = 1'b1;
            end
            ST_SEND_LO: begin
                w_code_nxt = W_LO;
                w_data_nxt = r_buf[w_idx_nxt][HORIZONTAL_DW-1:0];
                w_busy_nxt = 1'b1;
            end
            ST_GAP: begin
                w_busy_nxt = 1'b1;
                w_done_nxt = (w_gap_nxt == c_GAP_LAST);
            end
            default: begin
                w_code_nxt = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_idx   <= 2'd0;
            r_gap   <= '0;
            r_ready <= 1'b0;
            r_code  <= W_IDLE;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_gap   <= w_gap_nxt;
            r_ready <= w_ready_nxt;
            r_code  <= w_code_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_load_ready          = r_ready;
    assign o_rom6_w              = r_code;
    assign o_horizontal_data_out = r_data;
    assign o_busy                = r_busy;
    assign o_done                = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tw_horizontal_tx.sv
// ============================================================================
// Module : tb_tw_horizontal_tx
// Brief  : Randomised bench comparing two gap settings of tw_horizontal_tx
//          against a burst-offset reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tw_horizontal_tx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel;
    logic         lv;
    logic [127:0] ld;
    logic         en;

    logic         lv0, lv1, en0, en1;
    logic         rdy0, rdy1, busy0, busy1, done0, done1;
    logic [1:0]   code0, code1;
    logic [63:0]  data0, data1;
    logic         ob_ready, ob_busy, ob_done;
    logic [1:0]   ob_code;
    logic [63:0]  ob_data;

    int           n_checks = 0;
    int           n_errors = 0;

    // Reference model: m_t is the cycle offset inside the current burst (-1 idle)
    int           m_t;
    logic [127:0] m_q[$];
    bit           m_hold;
    int           m_gap;
    logic [127:0] dir_vec[4];

    always #5 clk = ~clk;

    assign lv0 = lv & ~sel;
    assign lv1 = lv & sel;
    assign en0 = en & ~sel;
    assign en1 = en & sel;

    assign ob_ready = sel ? rdy1  : rdy0;
    assign ob_busy  = sel ? busy1 : busy0;
    assign ob_done  = sel ? done1 : done0;
    assign ob_code  = sel ? code1 : code0;
    assign ob_data  = sel ? data1 : data0;

    tw_horizontal_tx #(.GAP_CYCLES(2)) u_dut_gap2 (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_load_valid          (lv0),
        .i_load_data           (ld),
        .o_load_ready          (rdy0),
        .i_tx_en               (en0),
        .o_horizontal_data_out (data0),
        .o_rom6_w              (code0),
        .o_busy                (busy0),
        .o_done                (done0)
    );

    tw_horizontal_tx #(.GAP_CYCLES(1)) u_dut_gap1 (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_load_valid          (lv1),
        .i_load_data           (ld),
        .o_load_ready          (rdy1),
        .i_tx_en               (en1),
        .o_horizontal_data_out (data1),
        .o_rom6_w              (code1),
        .o_busy                (busy1),
        .o_done                (done1)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [1:0]  e_code;
        logic [63:0] e_data;
        bit          e_busy, e_done, e_ready;
        e_code  = 2'd0;
        e_data  = 64'd0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_ready = !m_hold && (m_t < 0) && (m_q.size() < 4);
        if (m_t >= 0) begin
            e_busy = 1'b1;
            e_done = (m_t == 7 + m_gap);
            if (m_t < 4) begin
                e_code = 2'd1;
                e_data = m_q[m_t][127:64];
            end else if (m_t < 8) begin
                e_code = 2'd2;
                e_data = m_q[m_t-4][63:0];
            end
        end
        chk("ready", {127'd0, ob_ready}, {127'd0, e_ready});
        chk("code",  {126'd0, ob_code},  {126'd0, e_code});
        chk("data",  {64'd0, ob_data},   {64'd0, e_data});
        chk("busy",  {127'd0, ob_busy},  {127'd0, e_busy});
        chk("done",  {127'd0, ob_done},  {127'd0, e_done});
    endtask

    task automatic model_update(input bit v, input logic [127:0] d, input bit e);
        if (m_hold) begin
            m_hold = 1'b0;
        end else if (m_t >= 0) begin
            m_t++;
            if (m_t == 8 + m_gap) begin
                m_t = -1;
                m_q.delete();
            end
        end else if (m_q.size() < 4) begin
            if (v) m_q.push_back(d);
        end else if (e) begin
            m_t = 0;
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step(input bit v, input logic [127:0] d, input bit e);
        @(negedge clk);
        check_outputs();
        lv = v;
        ld = d;
        en = e;
        model_update(v, d, e);
    endtask

    // Reset lands mid-cycle so an asynchronous clear is visible within 1 ns.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_t   = -1;
        m_q.delete();
        m_hold = 1'b1;
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        lv = 1'b1;
        ld = rnd128();
        en = 1'b1;
        model_update(lv, ld, en);
    endtask

    task automatic run_random(input int cycles, input int en_den);
        for (int i = 0; i < cycles; i++) begin
            step(1'($urandom_range(0, 1)), rnd128(), ($urandom_range(0, en_den - 1) == 0));
        end
    endtask

    initial begin
        dir_vec[0] = 128'h0000000000000001_0000000000000001;
        dir_vec[1] = 128'h0200000000000000_585bda2e086ebc26;
        dir_vec[2] = 128'hfffffffefffc0001_00000007fff7fff8;
        dir_vec[3] = 128'hfffff7ff00000801_7202dad8187e103f;
        rst_n = 1'b0;
        sel   = 1'b0;
        lv    = 1'b0;
        ld    = '0;
        en    = 1'b0;
        m_gap = 2;
        m_t   = -1;
        m_hold = 1'b1;

        // Directed group with tx_en held high
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, dir_vec[m_q.size() % 4], 1'b1);
        end

        // Load, then hold tx_en low well past the fill; then back-to-back groups
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(1'($urandom_range(0, 1)), rnd128(), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, rnd128(), 1'b1);
        end

        run_random(400, 4);

        // Asynchronous reset during the third lower-half cycle
        begin
            int guard;
            guard = 0;
            while (m_t != 6 && guard < 100) begin
                step(1'b1, rnd128(), 1'b1);
                guard++;
            end
            chk("reach_send_lo3", {96'd0, 32'(m_t)}, 128'd6);
        end
        do_reset();
        run_random(60, 3);

        // Single-cycle gap variant
        sel   = 1'b1;
        m_gap = 1;
        do_reset();
        run_random(300, 3);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, rnd128(), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
